// File: rtl/lfsr_stream_checker_if.sv
// Observation bus between a 3-bit Galois LFSR and its stream checker.
// The master side drives the sample stream; the slave side reports status.
interface lfsr_stream_checker_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             resync;
    logic [2:0]       lfsr_in;
    logic             locked;
    logic             err;
    logic             stuck_zero;
    logic [3:0]       period;
    logic             period_valid;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, resync, lfsr_in,
        input  locked, err, stuck_zero, period, period_valid, err_cnt
    );

    modport slave (
        input  en, resync, lfsr_in,
        output locked, err, stuck_zero, period, period_valid, err_cnt
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Monitors a 3-bit Galois LFSR: checks the recurrence, measures the period,
// counts mismatches, flags the all-zero lockup and reports lock.
module lfsr_stream_checker #(
    parameter int ERR_W        = 8,
    parameter int LOCK_PERIODS = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    lfsr_stream_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        STUCK
    } state_t;

    localparam logic [2:0] LOCK_N = 3'(LOCK_PERIODS);

    state_t           state;
    logic [2:0]       ref_s;
    logic [2:0]       start_s;
    logic [3:0]       run;
    logic [2:0]       clean;
    logic             locked_q;
    logic             err_q;
    logic             stuck_q;
    logic [3:0]       period_q;
    logic             pv_q;
    logic [ERR_W-1:0] cnt_q;

    logic [2:0]       pred;
    logic             zero_in;
    logic             acq;
    logic             match;
    logic             miss;
    logic [3:0]       run_inc;
    logic [2:0]       clean_inc;
    logic [ERR_W-1:0] cnt_inc;

    always_comb begin
        pred      = {ref_s[2] ^ ref_s[1], ref_s[0], ref_s[2]};
        zero_in   = (bus.lfsr_in == 3'b000);
        acq       = bus.resync || (state != TRACK);
        match     = !acq && (bus.lfsr_in == pred);
        miss      = !acq && (bus.lfsr_in != pred);
        run_inc   = (run == 4'hF) ? run : run + 4'd1;
        clean_inc = (clean == 3'd7) ? clean : clean + 3'd1;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= IDLE;
            ref_s    <= '0;
            start_s  <= '0;
            run      <= '0;
            clean    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
            period_q <= '0;
            pv_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            err_q <= 1'b0;
            pv_q  <= 1'b0;
            if (bus.resync && !bus.en) begin
                state    <= IDLE;
                locked_q <= 1'b0;
                clean    <= '0;
            end else if (bus.en) begin
                stuck_q <= zero_in;
                unique case (1'b1)
                    match: begin
                        ref_s <= bus.lfsr_in;
                        if (bus.lfsr_in == start_s) begin
                            period_q <= run_inc;
                            pv_q     <= 1'b1;
                            run      <= '0;
                            clean    <= clean_inc;
                            locked_q <= (clean_inc >= LOCK_N);
                        end else begin
                            run <= run_inc;
                        end
                    end
                    // a mismatch counts, then restarts acquisition on the bad sample
                    acq, miss: begin
                        if (miss) begin
                            err_q <= 1'b1;
                            cnt_q <= cnt_inc;
                        end
                        ref_s    <= bus.lfsr_in;
                        start_s  <= bus.lfsr_in;
                        run      <= '0;
                        clean    <= '0;
                        locked_q <= 1'b0;
                        state    <= zero_in ? STUCK : TRACK;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.locked       = locked_q;
    assign bus.err          = err_q;
    assign bus.stuck_zero   = stuck_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.err_cnt      = cnt_q;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: vector table, directed corner cases and
// random stream against a cycle-table reference model.
module tb_lfsr_stream_checker;
    logic       clk;
    logic       arst_n;
    logic       en;
    logic       resync;
    logic [2:0] din;

    int checks = 0;
    int errors = 0;

    lfsr_stream_checker_if #(.ERR_W(8)) b1 ();
    lfsr_stream_checker_if #(.ERR_W(2)) b2 ();

    assign b1.en      = en;
    assign b1.resync  = resync;
    assign b1.lfsr_in = din;
    assign b2.en      = en;
    assign b2.resync  = resync;
    assign b2.lfsr_in = din;

    lfsr_stream_checker #(.ERR_W(8), .LOCK_PERIODS(1)) dut1 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (b1.slave)
    );

    lfsr_stream_checker #(.ERR_W(2), .LOCK_PERIODS(2)) dut2 (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference nonzero cycle; successor is the next entry
    localparam logic [2:0] CYC [7] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6};

    function automatic logic [2:0] succ(input logic [2:0] x);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 7; i++)
            if (CYC[i] == x) r = CYC[(i + 1) % 7];
        return r;
    endfunction

    bit         m_have;
    logic [2:0] m_last;
    logic [2:0] m_start;
    int         m_run;
    int         m_clean;
    bit         m_err;
    bit         m_stuck;
    int         m_period;
    bit         m_pv;
    int         m_ec1;
    int         m_ec2;

    task automatic model_reset();
        m_have = 0; m_last = 0; m_start = 0; m_run = 0; m_clean = 0;
        m_err = 0; m_stuck = 0; m_period = 0; m_pv = 0; m_ec1 = 0; m_ec2 = 0;
    endtask

    task automatic model_acquire(input logic [2:0] s);
        m_have  = 1;
        m_last  = s;
        m_start = s;
        m_run   = 0;
        m_clean = 0;
    endtask

    task automatic model_step(input logic e, input logic r, input logic [2:0] s);
        m_err = 0;
        m_pv  = 0;
        if (r && !e) begin
            m_have  = 0;
            m_clean = 0;
        end else if (e) begin
            m_stuck = (s == 3'd0);
            if (r || !m_have || m_last == 3'd0) begin
                model_acquire(s);
            end else if (s == succ(m_last)) begin
                m_last = s;
                m_run  = (m_run + 1 > 15) ? 15 : m_run + 1;
                if (s == m_start) begin
                    m_period = m_run;
                    m_pv     = 1;
                    m_run    = 0;
                    m_clean  = (m_clean + 1 > 7) ? 7 : m_clean + 1;
                end
            end else begin
                m_err = 1;
                m_ec1 = (m_ec1 + 1 > 255) ? 255 : m_ec1 + 1;
                m_ec2 = (m_ec2 + 1 > 3) ? 3 : m_ec2 + 1;
                model_acquire(s);
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input int exp);
        checks++;
        if (got !== exp[15:0]) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("locked",       16'(b1.locked),       int'(m_clean >= 1));
        chk("err",          16'(b1.err),          int'(m_err));
        chk("stuck_zero",   16'(b1.stuck_zero),   int'(m_stuck));
        chk("period",       16'(b1.period),       m_period);
        chk("period_valid", 16'(b1.period_valid), int'(m_pv));
        chk("err_cnt",      16'(b1.err_cnt),      m_ec1);
        chk("locked_lp2",   16'(b2.locked),       int'(m_clean >= 2));
        chk("err_w2",       16'(b2.err),          int'(m_err));
        chk("err_cnt_w2",   16'(b2.err_cnt),      m_ec2);
    endtask

    task automatic cycle(input logic e, input logic r, input logic [2:0] d);
        en = e;
        resync = r;
        din = d;
        @(posedge clk);
        model_step(e, r, d);
        #1;
        compare_model();
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        en = 1'b0;
        resync = 1'b0;
        din = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_model();
        arst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       rs;
        logic [2:0] din;
        logic       lk;
        logic       er;
        logic       sz;
        logic [3:0] per;
        logic       pv;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl [18];

    initial begin
        logic [2:0] seq [7];
        int         r;
        logic       e;
        logic       rs;
        logic [2:0] d;

        tbl[0]  = '{1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 4'd7, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[13] = '{1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[14] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[15] = '{1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[16] = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 8'd1};

        apply_reset();

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].en, tbl[i].rs, tbl[i].din);
            chk($sformatf("tbl%0d_locked", i), 16'(b1.locked), int'(tbl[i].lk));
            chk($sformatf("tbl%0d_err", i), 16'(b1.err), int'(tbl[i].er));
            chk($sformatf("tbl%0d_stuck", i), 16'(b1.stuck_zero), int'(tbl[i].sz));
            chk($sformatf("tbl%0d_period", i), 16'(b1.period), int'(tbl[i].per));
            chk($sformatf("tbl%0d_pv", i), 16'(b1.period_valid), int'(tbl[i].pv));
            chk($sformatf("tbl%0d_errcnt", i), 16'(b1.err_cnt), int'(tbl[i].ec));
        end

        // all-zero lockup from IDLE, then recovery
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 3'd0);
            chk("stuck_set", 16'(b1.stuck_zero), 1);
            chk("stuck_no_err", 16'(b1.err), 0);
        end
        cycle(1'b1, 1'b0, 3'd4);
        chk("stuck_clear", 16'(b1.stuck_zero), 0);
        chk("stuck_errcnt", 16'(b1.err_cnt), 0);

        // resync mid-sequence with seed 110
        cycle(1'b1, 1'b0, 3'd5);
        cycle(1'b1, 1'b0, 3'd7);
        cycle(1'b1, 1'b1, 3'd6);
        chk("resync_no_err", 16'(b1.err), 0);
        seq = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd7, 3'd3, 3'd6};
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, seq[i]);
        chk("resync_pv", 16'(b1.period_valid), 1);
        chk("resync_period", 16'(b1.period), 7);

        // en low for 5 cycles must not advance the transition count
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, seq[i]);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            chk("hold_locked", 16'(b1.locked), 1);
            chk("hold_pv", 16'(b1.period_valid), 0);
        end
        for (int i = 3; i < 7; i++) cycle(1'b1, 1'b0, seq[i]);
        chk("hold_pv_after", 16'(b1.period_valid), 1);
        chk("hold_period", 16'(b1.period), 7);

        // randomized stream
        for (int n = 0; n < 800; n++) begin
            r  = int'($urandom_range(0, 19));
            e  = ($urandom_range(0, 4) != 0);
            rs = ($urandom_range(0, 29) == 0);
            if (m_have && m_last != 3'd0 && r < 16) d = succ(m_last);
            else if (r < 18) d = 3'($urandom_range(0, 7));
            else d = 3'd0;
            cycle(e, rs, d);
        end

        // five back-to-back mismatches saturate the narrow counter
        cycle(1'b1, 1'b1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 3'd1);
            chk("miss_err", 16'(b1.err), 1);
        end
        chk("sat_errcnt_w2", 16'(b2.err_cnt), 3);

        // asynchronous reset between edges
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        chk("arst_errcnt", 16'(b1.err_cnt), 0);
        chk("arst_errcnt_w2", 16'(b2.err_cnt), 0);
        chk("arst_period", 16'(b1.period), 0);
        #1;
        arst_n = 1'b1;
        cycle(1'b1, 1'b0, 3'd5);
        chk("post_arst_no_err", 16'(b1.err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Sits directly downstream of the 3-bit muxed Galois LFSR and watches its state output every sampled cycle.
- Checks that each sample follows the Galois recurrence next = {s[2]^s[1], s[0], s[2]}.
- Measures the sequence period, flags mismatches and the stuck all-zero state, and asserts lock after clean periods.
- Gives the bench and on-board debug a self-checking monitor for the generator.

Parameters:
- ERR_W, 8, width of the saturating mismatch counter.
- LOCK_PERIODS, 1, consecutive clean full periods required before locked asserts (range 1..7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; lfsr_in is sampled on a rising edge only when en=1.
- resync  input  1  driven with the LFSR load control L. Next sample is a new seed, not a successor.
- lfsr_in  input  3  LFSR state under observation.
- locked  output  1  level; sequence has tracked cleanly for LOCK_PERIODS full periods.
- err  output  1  one-cycle pulse on a recurrence mismatch.
- stuck_zero  output  1  level; last sample was 000.
- period  output  4  last measured period, in transitions.
- period_valid  output  1  one-cycle pulse when period is updated.
- err_cnt  output  ERR_W  mismatch count, saturating at all-ones.

Behaviour:
- Reset (arst_n=0, asynchronous): state=IDLE, all outputs 0, ref/start/run registers 0. All state and outputs are registered.
- A sample is an edge with en=1. All outputs reflect that sample immediately after the edge. Pulses are high for exactly one clk.
- Internal registers:
  - ref: last sample.
  - start: acquisition sample.
  - run: 4-bit transition count since acquisition, saturating at 15.
  - clean: count of completed clean periods.
- States:
  - IDLE: no reference.
    - On a sample: ref=start=lfsr_in, run=0.
    - Go to STUCK if lfsr_in==000, else TRACK.
  - TRACK: compute pred = {ref[2]^ref[1], ref[0], ref[2]}.
    - Sample == pred, nonzero: ref=sample, run=run+1.
    - If also sample==start: period=run+1, period_valid=1, run=0, clean=clean+1. If clean reaches LOCK_PERIODS, locked=1. clean saturates.
    - Sample != pred: err=1, err_cnt+1 (saturating), locked=0, clean=0. Re-acquire: ref=start=sample, run=0. Go to STUCK if sample==000, else stay TRACK.
  - STUCK: stuck_zero=1 while samples are 000. No err is raised for 000 -> 000 (it is a legal recurrence).
    - Nonzero sample: stuck_zero=0, acquire as in IDLE, go to TRACK. No err.
    - locked stays 0 in STUCK.
- resync has priority over compare:
  - resync=1 with en=1: sample taken as a new seed (acquire as in IDLE). locked=0, clean=0, no err, err_cnt unchanged, period unchanged.
  - resync=1 with en=0: go to IDLE, locked=0, clean=0. stuck_zero and period hold.
- en=0 and resync=0: all registers hold.
- period holds its last value until the next completed period. Nominal value for any nonzero seed is 7 (4'd7).
- Reset mid-operation returns immediately to the reset values; err_cnt is cleared too.
- A reference nonzero cycle is 001,010,100,101,111,011,110,001.

Test Plan:
- Reset, then resync+en with 001, then 7 samples 010,100,101,111,011,110,001 -> period=7 with period_valid pulse on the 001 edge; locked=1 (LOCK_PERIODS=1); err_cnt=0.
- While locked, inject 011 where 101 is expected -> err pulse, err_cnt=1, locked=0. Tracking resumes from 011: 110,001,010,100,101,111,011 -> period=7, locked=1.
- Samples 000,000,000 from IDLE -> stuck_zero=1, no err. Then 100 -> stuck_zero=0, TRACK entered, err_cnt still 0.
- Mid-sequence, resync+en with seed 110 -> no err. Following 001,...,110 -> period=7 after 7 samples.
- en held low for 5 cycles mid-sequence -> all outputs hold, no period count advance.
- With ERR_W=2, 5 consecutive mismatches -> err_cnt saturates at 3. Then assert arst_n=0 asynchronously between edges -> all outputs 0 immediately.
